// File: rtl/echo.sv
// Feedback echo stage: each strobed sample is mixed with the stored output from
// `duration` samples earlier (attenuated), saturated, emitted and written back.
module echo #(
    parameter int WIDTH       = 16,
    parameter int ADDR_W      = 6,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     new_sample_in,
    input  logic [ADDR_W-1:0]        duration,
    input  logic signed [WIDTH-1:0]  sample_in,
    output logic signed [WIDTH-1:0]  sample_out,
    output logic                     new_sample_out,
    output logic [1:0]               o_dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_MIX   = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_strobe_d;
    logic                      w_start;
    logic                      w_latch;
    logic                      w_fetch;
    logic                      w_mix;
    logic [ADDR_W-1:0]         r_wr_ptr;
    logic [ADDR_W-1:0]         r_rd_addr;
    logic                      r_dur_zero;
    logic [DEPTH-1:0]          r_valid;
    logic signed [WIDTH-1:0]   r_mem [DEPTH];
    logic signed [WIDTH-1:0]   r_sample;
    logic signed [WIDTH-1:0]   r_delayed;
    logic signed [WIDTH-1:0]   r_sample_out;
    logic                      r_pulse;
    logic signed [WIDTH-1:0]   w_shifted;
    logic [WIDTH:0]            w_sum;
    logic signed [WIDTH-1:0]   w_result;

    assign w_start = new_sample_in & ~r_strobe_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Strobe edges arriving in FETCH/MIX are intentionally dropped.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_FETCH;
            S_FETCH: w_next_state = S_MIX;
            S_MIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_latch = 1'b0;
        w_fetch = 1'b0;
        w_mix   = 1'b0;
        case (r_state)
            S_IDLE:  w_latch = w_start;
            S_FETCH: w_fetch = 1'b1;
            S_MIX:   w_mix   = 1'b1;
            default: ;
        endcase
    end

    // Overflow of the 17-bit sum shows as disagreement between its top two bits.
    assign w_shifted = r_delayed >>> DECAY_SHIFT;
    assign w_sum     = {r_sample[WIDTH-1], r_sample} + {w_shifted[WIDTH-1], w_shifted};
    always_comb begin
        w_result = w_sum[WIDTH-1:0];
        if (w_sum[WIDTH] != w_sum[WIDTH-1]) begin
            w_result = w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_strobe_d   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_addr    <= '0;
            r_dur_zero   <= 1'b0;
            r_valid      <= '0;
            r_sample     <= '0;
            r_delayed    <= '0;
            r_sample_out <= '0;
            r_pulse      <= 1'b0;
        end else begin
            r_strobe_d <= new_sample_in;
            r_pulse    <= w_mix;
            if (w_latch) begin
                r_sample   <= sample_in;
                r_rd_addr  <= r_wr_ptr - duration;
                r_dur_zero <= (duration == '0);
            end
            if (w_fetch) begin
                r_delayed <= (!r_dur_zero && r_valid[r_rd_addr]) ? r_mem[r_rd_addr] : '0;
            end
            if (w_mix) begin
                r_sample_out       <= w_result;
                r_valid[r_wr_ptr]  <= 1'b1;
                r_wr_ptr           <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Buffer RAM is never cleared; the valid vector masks stale contents.
    always_ff @(posedge clk) begin
        if (!reset && w_mix) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    assign sample_out     = r_sample_out;
    assign new_sample_out = r_pulse;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_echo.sv
// Directed bench for the echo stage: latency, echo mixing, saturation,
// pass-through, strobe edge filtering and reset abort.
module tb_echo;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_sample_in;
    logic [5:0]  duration;
    logic [15:0] sample_in;
    logic [15:0] sample_out;
    logic        new_sample_out;
    logic [1:0]  o_dbg_state;

    int n_vec = 0;
    int n_err = 0;

    echo dut (
        .clk            (clk),
        .reset          (reset),
        .new_sample_in  (new_sample_in),
        .duration       (duration),
        .sample_in      (sample_in),
        .sample_out     (sample_out),
        .new_sample_out (new_sample_out),
        .o_dbg_state    (o_dbg_state)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are observed there too.
    task automatic do_reset();
        reset         = 1'b1;
        new_sample_in = 1'b0;
        duration      = '0;
        sample_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One strobe, then watch a bounded window; lat = clocks from strobe edge to pulse (-1 if none).
    task automatic send_sample(input logic [15:0] s, input logic [5:0] d,
                               output logic [15:0] out, output int lat, output int plen);
        sample_in     = s;
        duration      = d;
        new_sample_in = 1'b1;
        @(posedge clk);
        #1;
        new_sample_in = 1'b0;
        lat  = -1;
        plen = 0;
        out  = 16'hxxxx;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (new_sample_out) begin
                if (lat < 0) begin
                    lat = c;
                    out = sample_out;
                end
                plen++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (sample_out !== 16'h0000) begin
            n_err++; $display("FAIL reset_sample_out got %h want 0000", sample_out);
        end
        n_vec++;
        if (new_sample_out !== 1'b0) begin
            n_err++; $display("FAIL reset_pulse got %b want 0", new_sample_out);
        end
        n_vec++;
        if (o_dbg_state !== 2'd0) begin
            n_err++; $display("FAIL reset_state got %0d want 0", o_dbg_state);
        end
    endtask

    task automatic test_single();
        logic [15:0] out; int lat; int plen;
        do_reset();
        send_sample(16'h0888, 6'd16, out, lat, plen);
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL single_latency got %0d want 2", lat); end
        n_vec++;
        if (plen !== 1) begin n_err++; $display("FAIL single_pulse_len got %0d want 1", plen); end
        n_vec++;
        if (out !== 16'h0888) begin n_err++; $display("FAIL single_value got %h want 0888", out); end
        n_vec++;
        if (sample_out !== 16'h0888) begin
            n_err++; $display("FAIL single_hold got %h want 0888", sample_out);
        end
    endtask

    task automatic test_echo();
        logic [15:0] out; int lat; int plen;
        logic [15:0] exp;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            send_sample(16'h0888, 6'd16, out, lat, plen);
            exp = (i == 17) ? 16'h0CCC : 16'h0888;
            n_vec++;
            if (out !== exp || lat !== 2) begin
                n_err++; $display("FAIL echo_%0d got %h lat %0d want %h lat 2", i, out, lat, exp);
            end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] out; int lat; int plen;
        logic [15:0] pos_exp [3] = '{16'h7000, 16'h7FFF, 16'h7FFF};
        logic [15:0] neg_exp [3] = '{16'h8000, 16'h8000, 16'h8000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_sample(16'h7000, 6'd1, out, lat, plen);
            n_vec++;
            if (out !== pos_exp[i]) begin
                n_err++; $display("FAIL sat_pos_%0d got %h want %h", i, out, pos_exp[i]);
            end
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_sample(16'h8000, 6'd1, out, lat, plen);
            n_vec++;
            if (out !== neg_exp[i]) begin
                n_err++; $display("FAIL sat_neg_%0d got %h want %h", i, out, neg_exp[i]);
            end
        end
        // Unsaturated negative echo: -0x1000 + (-0x1000 >>> 1) = -0x1800.
        do_reset();
        send_sample(16'hF000, 6'd1, out, lat, plen);
        send_sample(16'hF000, 6'd1, out, lat, plen);
        n_vec++;
        if (out !== 16'hE800) begin n_err++; $display("FAIL neg_echo got %h want e800", out); end
    endtask

    task automatic test_passthrough();
        logic [15:0] out; int lat; int plen;
        logic [15:0] vec [6] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hABCD};
        do_reset();
        // Fill every slot so a stale entry would be visible if duration 0 leaked feedback.
        for (int i = 0; i < 64; i++) send_sample(16'h4000, 6'd0, out, lat, plen);
        for (int i = 0; i < 6; i++) begin
            send_sample(vec[i], 6'd0, out, lat, plen);
            n_vec++;
            if (out !== vec[i] || lat !== 2) begin
                n_err++; $display("FAIL pass_%0d got %h lat %0d want %h lat 2", i, out, lat, vec[i]);
            end
        end
    endtask

    task automatic test_strobe_filter();
        int pulses;
        logic [15:0] first;
        do_reset();
        sample_in = 16'h0100; duration = 6'd0; new_sample_in = 1'b1;
        pulses = 0; first = 16'hxxxx;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 3) new_sample_in = 1'b0;
            if (new_sample_out) begin pulses++; if (pulses == 1) first = sample_out; end
        end
        n_vec++;
        if (pulses !== 1) begin n_err++; $display("FAIL held_strobe pulses got %0d want 1", pulses); end
        n_vec++;
        if (first !== 16'h0100) begin n_err++; $display("FAIL held_value got %h want 0100", first); end
        // Second rising edge lands while busy and must be ignored.
        sample_in = 16'h0200; new_sample_in = 1'b1;
        pulses = 0; first = 16'hxxxx;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 0) new_sample_in = 1'b0;
            if (c == 1) begin new_sample_in = 1'b1; sample_in = 16'h0300; end
            if (c == 2) new_sample_in = 1'b0;
            if (new_sample_out) begin pulses++; if (pulses == 1) first = sample_out; end
        end
        n_vec++;
        if (pulses !== 1) begin n_err++; $display("FAIL busy_edge pulses got %0d want 1", pulses); end
        n_vec++;
        if (first !== 16'h0200) begin n_err++; $display("FAIL busy_edge_value got %h want 0200", first); end
    endtask

    task automatic test_reset_abort();
        logic [15:0] out; int lat; int plen;
        int pulses;
        do_reset();
        for (int i = 0; i < 64; i++) send_sample(16'h2000, 6'd0, out, lat, plen);
        sample_in = 16'h1111; duration = 6'd0; new_sample_in = 1'b1;
        @(posedge clk); #1;
        new_sample_in = 1'b0;
        n_vec++;
        if (o_dbg_state !== 2'd1) begin n_err++; $display("FAIL fetch_state got %0d want 1", o_dbg_state); end
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) reset = 1'b0;
            if (new_sample_out) pulses++;
        end
        n_vec++;
        if (pulses !== 0) begin n_err++; $display("FAIL abort_pulses got %0d want 0", pulses); end
        n_vec++;
        if (sample_out !== 16'h0000) begin
            n_err++; $display("FAIL abort_sample_out got %h want 0000", sample_out);
        end
        send_sample(16'h0888, 6'd16, out, lat, plen);
        n_vec++;
        if (out !== 16'h0888) begin n_err++; $display("FAIL post_reset_no_echo got %h want 0888", out); end
        // wr_ptr restarted at 0, so duration 1 now reads the sample just written.
        send_sample(16'h0888, 6'd1, out, lat, plen);
        n_vec++;
        if (out !== 16'h0CCC) begin n_err++; $display("FAIL post_reset_ptr got %h want 0ccc", out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_echo();
        test_saturate();
        test_passthrough();
        test_strobe_filter();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
